// File: rtl/vga_fb_arbiter_if.sv
// Writer handshake and frame-buffer SRAM bus shared by the arbiter and its environment.
// slave = arbiter side, master = writer/SRAM side.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 19
);
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport master (
    output wr_valid, wr_addr, wr_data, mem_rdata,
    input  wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, mem_rdata,
    output wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer SRAM arbiter: linear scan-out prefetch into a pixel FIFO (high priority)
// with every spare memory cycle handed to a valid/ready image-processing writer.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WATER  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_frame_start,
  input  logic       i_pix_pop,
  output logic       o_pix_valid,
  output logic [7:0] o_pix_data,
  output logic       o_underflow,
  vga_fb_arbiter_if.slave bus
);

  localparam int DATA_W    = 8;
  localparam int IDX_W     = $clog2(FIFO_DEPTH);
  localparam int PTR_W     = IDX_W + 1;
  localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);
  localparam logic [PTR_W-1:0]  DEPTH_L   = PTR_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  LOW_L     = PTR_W'(LOW_WATER);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_vld_p1;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic              r_underflow;
  logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];

  logic [PTR_W-1:0]  w_level;
  logic              w_empty;
  logic [PTR_W-1:0]  w_occ;
  logic [PTR_W-1:0]  w_occ_eff;
  logic [ADDR_W-1:0] w_addr_eff;
  logic              w_fetch;
  logic              w_rd_sel;
  logic              w_wr_ready;
  logic              w_wr_fire;
  logic              w_pop;

  assign w_level = r_wptr - r_rptr;
  assign w_empty = (w_level == '0);
  assign w_occ   = w_level + {{(PTR_W-1){1'b0}}, r_rd_vld_p1};

  // A frame_start cycle already behaves as FETCH on a flushed FIFO, so address 0
  // is issued in the pulse cycle itself and the first pixel is ready two cycles later.
  assign w_fetch    = !reset && (i_frame_start || (r_state == FETCH));
  assign w_occ_eff  = i_frame_start ? '0 : w_occ;
  assign w_addr_eff = i_frame_start ? '0 : r_rd_addr;

  assign w_rd_sel   = w_fetch && ((w_occ_eff < LOW_L) ||
                                  ((w_occ_eff < DEPTH_L) && !bus.wr_valid));
  assign w_wr_ready = !reset && !w_rd_sel;
  assign w_wr_fire  = bus.wr_valid && w_wr_ready;
  assign w_pop      = i_pix_pop && !w_empty && !i_frame_start;

  assign bus.wr_ready = w_wr_ready;
  assign o_pix_valid  = !w_empty;
  assign o_pix_data   = w_empty ? '0 : r_fifo[r_rptr[IDX_W-1:0]];
  assign o_underflow  = r_underflow;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (w_rd_sel) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = w_addr_eff;
    end else if (w_wr_fire) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = bus.wr_addr;
      bus.mem_wdata = bus.wr_data;
    end
  end

  // Stage p0 -> p1: read issued, return expected next cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rd_addr   <= '0;
      r_rd_vld_p1 <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (i_pix_pop && w_empty)
        r_underflow <= 1'b1;

      r_rd_vld_p1 <= w_rd_sel;
      if (w_rd_sel)
        r_rd_addr <= w_addr_eff + ADDR_W'(1);
      else if (i_frame_start)
        r_rd_addr <= '0;

      if (i_frame_start) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (r_rd_vld_p1)
          r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop)
          r_rptr <= r_rptr + PTR_W'(1);
      end

      case (r_state)
        IDLE:    if (i_frame_start) r_state <= FETCH;
        FETCH:   if (!i_frame_start && w_rd_sel && (r_rd_addr == LAST_ADDR))
                   r_state <= DONE;
        DONE:    if (i_frame_start) r_state <= FETCH;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stage p1 -> FIFO: a return whose read predates a flush is dropped
  always_ff @(posedge clk) begin
    if (r_rd_vld_p1 && !i_frame_start)
      r_fifo[r_wptr[IDX_W-1:0]] <= bus.mem_rdata;
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: directed vectors and sequences plus randomized
// traffic, all compared against a queue-based behavioural model of the arbiter.
module tb_vga_fb_arbiter;
  localparam int ADDR_W = 19;
  localparam int H_ACT  = 16;
  localparam int V_ACT  = 4;
  localparam int DEPTH  = 16;
  localparam int LW     = 8;
  localparam int NPIX   = H_ACT * V_ACT;
  localparam int H_TOT  = 20;
  localparam int V_TOT  = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       pix_pop;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       underflow;

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  vga_fb_arbiter #(
    .ADDR_W(ADDR_W), .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT),
    .FIFO_DEPTH(DEPTH), .LOW_WATER(LW)
  ) dut (
    .clk(clk), .reset(reset),
    .i_frame_start(frame_start), .i_pix_pop(pix_pop),
    .o_pix_valid(pix_valid), .o_pix_data(pix_data), .o_underflow(underflow),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // SRAM environment: one access per cycle, read data one cycle after the read
  logic [7:0] sram [0:(1<<ADDR_W)-1];
  logic [7:0] rdata_q = 8'h00;
  assign bus.mem_rdata = rdata_q;

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 37 + 11) & 255);
  endfunction

  initial for (int i = 0; i < (1<<ADDR_W); i++) sram[i] = init_val(i);

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) sram[bus.mem_addr] = bus.mem_wdata;
      else            rdata_q <= sram[bus.mem_addr];
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Behavioural model: pixel queue, one in-flight read, next linear address
  logic [7:0] q [$];
  bit         m_fetch = 0;
  bit         m_infl  = 0;
  logic [7:0] m_infl_data = 8'h00;
  int         m_next_addr = 0;
  bit         m_uf = 0;
  bit         e_rd, e_wr, e_ready;
  int         e_addr;

  logic              s_pv, s_uf, s_rdy, s_en, s_we;
  logic [7:0]        s_pd, s_wd;
  logic [ADDR_W-1:0] s_ma;

  task automatic cycle();
    int occ;
    bit fet;
    logic [7:0] cap;
    logic [ADDR_W-1:0] ea, x_ma;
    logic [7:0] x_pd, x_wd;
    @(negedge clk);
    if (reset) begin
      q.delete(); m_fetch = 0; m_infl = 0; m_next_addr = 0; m_uf = 0;
    end
    fet     = !reset && (frame_start || m_fetch);
    occ     = frame_start ? 0 : q.size() + int'(m_infl);
    e_addr  = frame_start ? 0 : m_next_addr;
    e_rd    = fet && (occ < LW || (occ < DEPTH && !bus.wr_valid));
    e_ready = !reset && !e_rd;
    e_wr    = bus.wr_valid && e_ready;
    ea      = ADDR_W'(e_addr);
    x_ma    = e_rd ? ea : (e_wr ? bus.wr_addr : '0);
    x_wd    = (!e_rd && e_wr) ? bus.wr_data : 8'h00;
    x_pd    = (q.size() > 0) ? q[0] : 8'h00;
    s_pv = pix_valid; s_pd = pix_data; s_uf = underflow; s_rdy = bus.wr_ready;
    s_en = bus.mem_en; s_we = bus.mem_we; s_ma = bus.mem_addr; s_wd = bus.mem_wdata;
    chk("pix_valid", 32'(s_pv),  32'(q.size() > 0));
    chk("pix_data",  32'(s_pd),  32'(x_pd));
    chk("underflow", 32'(s_uf),  32'(m_uf));
    chk("wr_ready",  32'(s_rdy), 32'(e_ready));
    chk("mem_en",    32'(s_en),  32'(e_rd || e_wr));
    chk("mem_we",    32'(s_we),  32'(!e_rd && e_wr));
    chk("mem_addr",  32'(s_ma),  32'(x_ma));
    chk("mem_wdata", 32'(s_wd),  32'(x_wd));
    cap = sram[ea];
    @(posedge clk);
    if (!reset) begin
      if (pix_pop && q.size() == 0) m_uf = 1;
      if (frame_start) begin
        q.delete(); m_fetch = 1;
      end else begin
        if (pix_pop && q.size() > 0) void'(q.pop_front());
        if (m_infl) q.push_back(m_infl_data);
      end
      m_infl = e_rd;
      if (e_rd) begin
        m_infl_data = cap;
        m_next_addr = e_addr + 1;
        if (e_addr == NPIX - 1) m_fetch = 0;
      end
    end
    #1;
  endtask

  // Writer: holds address/data until accepted, otherwise draws a new request
  task automatic drive_writer(input bit en, input bit hi_only);
    if (bus.wr_valid && !e_wr) return;
    bus.wr_valid = en ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.wr_addr  = hi_only ? ADDR_W'(32'h40000 + $urandom_range(0, 1023))
                           : ADDR_W'($urandom_range(0, 255));
    bus.wr_data  = 8'($urandom);
  endtask

  typedef struct {
    logic              wv;
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] ma;
    logic [7:0]        md;
    logic              rdy;
  } vec_t;
  vec_t vt [5];

  task automatic run_table(input string tag);
    for (int i = 0; i < 5; i++) begin
      bus.wr_valid = vt[i].wv; bus.wr_addr = vt[i].a; bus.wr_data = vt[i].d;
      pix_pop = 0; frame_start = 0;
      cycle();
      chk($sformatf("%s_en%0d", tag, i),    32'(s_en),  32'(vt[i].en));
      chk($sformatf("%s_we%0d", tag, i),    32'(s_we),  32'(vt[i].we));
      chk($sformatf("%s_addr%0d", tag, i),  32'(s_ma),  32'(vt[i].ma));
      chk($sformatf("%s_wdata%0d", tag, i), 32'(s_wd),  32'(vt[i].md));
      chk($sformatf("%s_ready%0d", tag, i), 32'(s_rdy), 32'(vt[i].rdy));
    end
    bus.wr_valid = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pv"},  32'(s_pv),  0);
    chk({tag, "_pd"},  32'(s_pd),  0);
    chk({tag, "_uf"},  32'(s_uf),  0);
    chk({tag, "_rdy"}, 32'(s_rdy), 0);
    chk({tag, "_en"},  32'(s_en),  0);
    chk({tag, "_we"},  32'(s_we),  0);
    chk({tag, "_ma"},  32'(s_ma),  0);
    chk({tag, "_wd"},  32'(s_wd),  0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int reads;
    int pidx;
    int line;
    vt[0] = '{1'b0, 19'h12345, 8'hA5, 1'b0, 1'b0, 19'h00000, 8'h00, 1'b1};
    vt[1] = '{1'b1, 19'h12345, 8'hA5, 1'b1, 1'b1, 19'h12345, 8'hA5, 1'b1};
    vt[2] = '{1'b1, 19'h7FFFF, 8'hFF, 1'b1, 1'b1, 19'h7FFFF, 8'hFF, 1'b1};
    vt[3] = '{1'b1, 19'h40001, 8'h3C, 1'b1, 1'b1, 19'h40001, 8'h3C, 1'b1};
    vt[4] = '{1'b0, 19'h7FFFF, 8'hFF, 1'b0, 1'b0, 19'h00000, 8'h00, 1'b1};

    reset = 1; frame_start = 0; pix_pop = 0;
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
    repeat (3) cycle();
    check_all_zero("reset");
    reset = 0;
    cycle();
    run_table("idle");

    // First fetch: back-to-back reads from 0, pixel two cycles after the pulse
    frame_start = 1;
    cycle();
    chk("ff_issue_en", 32'(s_en), 1);
    chk("ff_issue_addr", 32'(s_ma), 0);
    chk("ff_issue_ready", 32'(s_rdy), 0);
    frame_start = 0;
    reads = 1;
    cycle();
    if (s_en && !s_we) reads++;
    chk("ff_pv_t1", 32'(s_pv), 0);
    cycle();
    if (s_en && !s_we) reads++;
    chk("ff_pv_t2", 32'(s_pv), 1);
    chk("ff_pd_t2", 32'(s_pd), 32'(init_val(0)));
    repeat (25) begin
      cycle();
      if (s_en && !s_we) reads++;
    end
    chk("ff_reads_to_full", 32'(reads), 16);
    chk("ff_idle_en", 32'(s_en), 0);

    // Priority: level 10 with writer active, then pop down to 7
    bus.wr_valid = 1; bus.wr_addr = 19'h40000; bus.wr_data = 8'h5A;
    pix_pop = 1;
    repeat (6) cycle();
    pix_pop = 0;
    repeat (4) begin
      cycle();
      chk("prio_wr_ready", 32'(s_rdy), 1);
      chk("prio_wr_we", 32'(s_we), 1);
    end
    pix_pop = 1;
    repeat (3) cycle();
    pix_pop = 0;
    cycle();
    chk("prio_rd_en", 32'(s_en), 1);
    chk("prio_rd_we", 32'(s_we), 0);
    chk("prio_rd_ready", 32'(s_rdy), 0);
    bus.wr_valid = 0;

    // Reset in the middle of a fetch
    reset = 1;
    cycle();
    check_all_zero("midrst");
    reset = 0;
    cycle();

    // Flush with 5 entries held and one read in flight
    frame_start = 1; cycle(); frame_start = 0;
    cycle();
    pix_pop = 1; repeat (2) cycle(); pix_pop = 0;
    repeat (4) cycle();
    frame_start = 1; cycle(); frame_start = 0;
    cycle();
    chk("flush_pv_t1", 32'(s_pv), 0);
    cycle();
    chk("flush_pv_t2", 32'(s_pv), 1);
    chk("flush_head", 32'(s_pd), 32'(init_val(0)));
    pix_pop = 1; cycle(); pix_pop = 0;

    // Underflow: sticky across frame_start, cleared only by reset
    reset = 1; cycle(); reset = 0; cycle();
    pix_pop = 1; cycle(); pix_pop = 0;
    chk("uf_pd_empty", 32'(s_pd), 0);
    chk("uf_pv_empty", 32'(s_pv), 0);
    cycle();
    chk("uf_set", 32'(s_uf), 1);
    frame_start = 1; cycle(); frame_start = 0;
    repeat (5) cycle();
    chk("uf_sticky", 32'(s_uf), 1);
    reset = 1; cycle();
    chk("uf_reset", 32'(s_uf), 0);
    reset = 0; cycle();

    // Two full frames with scaled blanking and background writes
    for (int f = 0; f < 2; f++) begin
      pidx = 0;
      for (int ln = 0; ln < V_TOT; ln++) begin
        line = (V_ACT + ln) % V_TOT;
        for (int col = 0; col < H_TOT; col++) begin
          frame_start = (ln == 0 && col == 0);
          pix_pop     = (line < V_ACT) && (col < H_ACT);
          drive_writer(1, 1);
          cycle();
          if (pix_pop) begin
            chk($sformatf("scan_pv_f%0d_p%0d", f, pidx), 32'(s_pv), 1);
            chk($sformatf("scan_pd_f%0d_p%0d", f, pidx), 32'(s_pd), 32'(init_val(pidx)));
            pidx++;
          end
        end
      end
    end
    frame_start = 0; pix_pop = 0;
    chk("scan_no_underflow", 32'(s_uf), 0);
    bus.wr_valid = 1; bus.wr_addr = 19'h40010; bus.wr_data = 8'h77;
    repeat (8) begin
      cycle();
      chk("done_wr_ready", 32'(s_rdy), 1);
    end
    bus.wr_valid = 0;
    run_table("done");

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      reset       = ($urandom_range(0, 699) == 0);
      frame_start = ($urandom_range(0, 149) == 0);
      pix_pop     = 1'($urandom_range(0, 1));
      drive_writer(1, 0);
      cycle();
    end
    reset = 0; frame_start = 0; pix_pop = 0; bus.wr_valid = 0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
